// File: rtl/dffram_nr1w_lanes.sv
// Parametrised DFF RAM storage core: NRPORTS read ports, one lane-masked write port.
// Read latency 0 cycles (r_buf=0) or 1 cycle (r_buf=1); writes commit on the clock edge.
// No backpressure: a clear sequence runs for DEPTH cycles after reset/init_req, with init_busy high.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   init_req       restart the clear sequence (honoured only when READY)
//   w_en/w_addr/w_mask/w_data   masked lane write
//   write_through  merge a same-cycle write into matching read ports
//   r_addr/r_buf   per-port read address and output-register select
//   r_data         per-port read data
//   init_busy      clear sequence in progress
module dffram_nr1w_lanes #(
  parameter int AWIDTH  = 5,
  parameter int DEPTH   = 26,
  parameter int DWIDTH  = 8,
  parameter int LANES   = 2,
  parameter int NRPORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_req,
  input  logic                      w_en,
  input  logic [AWIDTH-1:0]         w_addr,
  input  logic [LANES-1:0]          w_mask,
  input  logic [DWIDTH-1:0]         w_data,
  input  logic                      write_through,
  input  logic [NRPORTS*AWIDTH-1:0] r_addr,
  input  logic [NRPORTS-1:0]        r_buf,
  output logic [NRPORTS*DWIDTH-1:0] r_data,
  output logic                      init_busy
);

  localparam int                LW      = DWIDTH / LANES;
  // One extra bit so DEPTH == 2**AWIDTH is representable for the range compare.
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t              state;
  logic [AWIDTH-1:0]   cnt;
  logic [DWIDTH-1:0]   mem   [DEPTH];
  logic [DWIDTH-1:0]   rbuf  [NRPORTS];
  logic [DWIDTH-1:0]   c_dat [NRPORTS];
  logic [DWIDTH-1:0]   m_dat [NRPORTS];
  logic [AWIDTH-1:0]   ra    [NRPORTS];
  logic [DWIDTH-1:0]   wmask_bits;
  logic                w_in_range;
  logic                wr_act;

  assign init_busy  = (state == INIT);
  assign w_in_range = ({1'b0, w_addr} < DEPTH_W);
  assign wr_act     = (state == READY) && w_en && w_in_range;

  // Expand the lane mask to a per-bit mask.
  always_comb begin
    wmask_bits = '0;
    for (int k = 0; k < LANES; k++) begin
      wmask_bits[k*LW +: LW] = {LW{w_mask[k]}};
    end
  end

  // Sequencer: INIT walks cnt over every implemented word, then hands over to READY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == LAST) begin
            state <= READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AWIDTH'(1);
          end
        end
        READY: begin
          if (init_req) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array carries no reset; it is cleared by the INIT walk instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else if (wr_act) begin
        mem[w_addr] <= (mem[w_addr] & ~wmask_bits) | (w_data & wmask_bits);
      end
    end
  end

  // Combinational read value per port, including the optional write merge.
  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      ra[p]    = r_addr[p*AWIDTH +: AWIDTH];
      m_dat[p] = ({1'b0, ra[p]} < DEPTH_W) ? mem[ra[p]] : '0;
      if (state == INIT) begin
        c_dat[p] = '0;
      end else if (write_through && wr_act && (w_addr == ra[p])) begin
        c_dat[p] = (m_dat[p] & ~wmask_bits) | (w_data & wmask_bits);
      end else begin
        c_dat[p] = m_dat[p];
      end
    end
  end

  // Output registers track c_dat every cycle regardless of r_buf, so switching
  // a port to buffered mode shows the previous cycle's value straight away.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NRPORTS; p++) begin
      if (!rst_n) begin
        rbuf[p] <= '0;
      end else begin
        rbuf[p] <= c_dat[p];
      end
    end
  end

  always_comb begin
    r_data = '0;
    for (int p = 0; p < NRPORTS; p++) begin
      r_data[p*DWIDTH +: DWIDTH] = r_buf[p] ? rbuf[p] : c_dat[p];
    end
  end

endmodule
